// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths and types for the register-file write path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  // Width of one register-file word
  localparam int DATA_W   = 64;
  // Register address width; the file holds 2**ADDR_W entries
  localparam int ADDR_W   = 5;
  // Hardwired-zero register; writes to it are accepted but dropped
  localparam int ZERO_REG = 31;
  // Number of architectural registers (one word-select line each)
  localparam int NUM_REGS = 2 ** ADDR_W;

  // One pending register-file write
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_wr_arbiter_dec.sv
// ============================================================================
// Module      : dec_stage / dec_5to32
// Description : Enabled one-hot decoders. dec_5to32 is a two-level tree: a
//               2-to-4 stage on the upper address bits enables one of four
//               3-to-8 banks, matching the register-file word-line decoders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_stage #(
  parameter int N = 2
) (
  input  logic [N-1:0]      addr_i,
  input  logic              en_i,
  output logic [2**N-1:0]   sel_o
);

  // Single enabled one-hot decode of addr_i
  always_comb begin
    sel_o = '0;
    if (en_i) begin
      sel_o[addr_i] = 1'b1;
    end
  end

endmodule : dec_stage

module dec_5to32 (
  input  logic [4:0]  addr_i,
  input  logic        en_i,
  output logic [31:0] sel_o
);

  // One enable per bank of eight word lines
  logic [3:0] bank_en;

  // Upper two bits pick the bank; gated by the overall enable
  dec_stage #(
    .N (2)
  ) u_bank_dec (
    .addr_i (addr_i[4:3]),
    .en_i   (en_i),
    .sel_o  (bank_en)
  );

  // Lower three bits pick the word inside the enabled bank
  for (genvar b = 0; b < 4; b++) begin : g_bank
    dec_stage #(
      .N (3)
    ) u_word_dec (
      .addr_i (addr_i[2:0]),
      .en_i   (bank_en[b]),
      .sel_o  (sel_o[b*8 +: 8])
    );
  end

endmodule : dec_5to32

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Round-robin arbiter sharing the register-file write port
//               between execute writeback (req0) and load writeback (req1).
//               The winning write is registered one cycle and decoded onto
//               one-hot word selects; writes to the zero register are
//               acknowledged but never issued. Contested cycles are counted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,

  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,

  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [2**ADDR_W-1:0] wr_sel,
  output logic [15:0]          stall_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [15:0]       STALL_MAX = 16'hFFFF;

  // Round-robin pointer: 0 favours req0, 1 favours req1
  logic prio_q;
  logic prio_d;

  // Registered write stage
  logic              wr_en_q;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] wr_data_d;

  // Contested-cycle counter
  logic [15:0] stall_q;
  logic [15:0] stall_d;

  // Arbitration results for the current cycle
  logic              gnt0;
  logic              gnt1;
  logic              contested;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // Grant decision; readies are forced low while reset is held so nothing
  // can be acknowledged that the write stage would then throw away
  always_comb begin
    contested = req0_valid & req1_valid;
    gnt0      = ~reset & req0_valid & (~req1_valid | ~prio_q);
    gnt1      = ~reset & req1_valid & (~req0_valid |  prio_q);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Select the winning request's payload (don't-care when nobody wins)
  always_comb begin
    gnt_addr = req0_addr;
    gnt_data = req0_data;
    if (gnt1) begin
      gnt_addr = req1_addr;
      gnt_data = req1_data;
    end
  end

  // Next-state for priority, write stage and stall counter
  always_comb begin
    prio_d    = prio_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    stall_d   = stall_q;

    // Every grant, contested or not, hands priority to the other side
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end

    // Capture the transfer; a zero-register target still releases the
    // requester but leaves this write slot empty
    if (gnt0 | gnt1) begin
      wr_addr_d = gnt_addr;
      wr_data_d = gnt_data;
      wr_en_d   = (gnt_addr != ZERO_ADDR);
    end

    // Count contested cycles, sticking at the maximum
    if (contested && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State registers; reset clears any in-flight write at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      stall_q   <= '0;
    end else begin
      prio_q    <= prio_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      stall_q   <= stall_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign stall_cnt = stall_q;

  // Word-select decode gated by the write enable
  if (ADDR_W == 5) begin : g_dec_tree
    dec_5to32 u_dec (
      .addr_i (wr_addr_q),
      .en_i   (wr_en_q),
      .sel_o  (wr_sel)
    );
  end else begin : g_dec_flat
    dec_stage #(
      .N (ADDR_W)
    ) u_dec (
      .addr_i (wr_addr_q),
      .en_i   (wr_en_q),
      .sel_o  (wr_sel)
    );
  end

endmodule : regfile_wr_arbiter

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Self-checking bench for regfile_wr_arbiter: directed vector
//               table, reset corner cases, random traffic against a
//               behavioural model, and stall counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr,  req1_addr;
  logic [63:0] req0_data,  req1_data;
  logic        req0_ready, req1_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [31:0] wr_sel;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_sel     (wr_sel),
    .stall_cnt  (stall_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // favour: which requester wins the next tie; pending: the write issued
  int      favour;
  bit      m_en;
  wr_req_t m_wr;
  int      m_stall;

  task automatic model_reset();
    favour  = 0;
    m_en    = 1'b0;
    m_wr    = '0;
    m_stall = 0;
  endtask

  function automatic bit model_ready(int who, bit v0, bit v1);
    if (who == 0) return v0 && (!v1 || favour == 0);
    return v1 && (!v0 || favour == 1);
  endfunction

  task automatic model_clock(bit v0, logic [4:0] a0, logic [63:0] d0,
                             bit v1, logic [4:0] a1, logic [63:0] d1);
    int winner;
    winner = model_ready(0, v0, v1) ? 0 : (model_ready(1, v0, v1) ? 1 : -1);
    if (v0 && v1) m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
    if (winner < 0) begin
      m_en = 1'b0;
    end else begin
      m_wr.addr = (winner == 0) ? a0 : a1;
      m_wr.data = (winner == 0) ? d0 : d1;
      m_en      = (int'(m_wr.addr) != ZERO_REG);
      favour    = 1 - winner;
    end
  endtask

  function automatic logic [63:0] model_sel();
    logic [63:0] s;
    s = 64'd0;
    if (m_en) s = 64'd1 << m_wr.addr;
    return s;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(bit v0, logic [4:0] a0, logic [63:0] d0,
                       bit v1, logic [4:0] a1, logic [63:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  // One clock: drive, check readies before the edge, check registered
  // outputs 2 time units after it. Entered between edges.
  task automatic cycle(bit v0, logic [4:0] a0, logic [63:0] d0,
                       bit v1, logic [4:0] a1, logic [63:0] d1, bit do_chk);
    drive(v0, a0, d0, v1, a1, d1);
    #1;
    if (do_chk) begin
      chk("req0_ready", req0_ready, model_ready(0, v0, v1));
      chk("req1_ready", req1_ready, model_ready(1, v0, v1));
    end
    @(posedge clk);
    model_clock(v0, a0, d0, v1, a1, d1);
    #2;
    if (do_chk) begin
      chk("wr_en",     wr_en,     m_en);
      chk("wr_addr",   wr_addr,   m_wr.addr);
      chk("wr_data",   wr_data,   m_wr.data);
      chk("wr_sel",    wr_sel,    model_sel());
      chk("stall_cnt", stall_cnt, 64'(m_stall));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          v0; logic [4:0] a0; logic [63:0] d0;
    bit          v1; logic [4:0] a1; logic [63:0] d1;
    bit          r0; bit r1;
    bit          en; logic [4:0] addr; logic [63:0] data;
    logic [31:0] sel; logic [15:0] stall;
  } vec_t;

  vec_t tv [8];

  initial begin
    tv[0] = '{1'b0, 5'd0, 64'd0,    1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 5'd5,  64'hDEAD_BEEF, 32'h0000_0020, 16'd0};
    tv[1] = '{1'b1, 5'd1, 64'h11,   1'b1, 5'd2, 64'h22,        1'b1, 1'b0, 1'b1, 5'd1,  64'h11,        32'h0000_0002, 16'd1};
    tv[2] = '{1'b1, 5'd1, 64'h11,   1'b1, 5'd2, 64'h22,        1'b0, 1'b1, 1'b1, 5'd2,  64'h22,        32'h0000_0004, 16'd2};
    tv[3] = '{1'b1, 5'd1, 64'h11,   1'b1, 5'd2, 64'h22,        1'b1, 1'b0, 1'b1, 5'd1,  64'h11,        32'h0000_0002, 16'd3};
    tv[4] = '{1'b1, 5'd1, 64'h11,   1'b1, 5'd2, 64'h22,        1'b0, 1'b1, 1'b1, 5'd2,  64'h22,        32'h0000_0004, 16'd4};
    tv[5] = '{1'b1, 5'd31, 64'h33,  1'b0, 5'd0, 64'd0,         1'b1, 1'b0, 1'b0, 5'd31, 64'h33,        32'h0000_0000, 16'd4};
    tv[6] = '{1'b1, 5'd3, 64'h44,   1'b1, 5'd4, 64'h55,        1'b0, 1'b1, 1'b1, 5'd4,  64'h55,        32'h0000_0010, 16'd5};
    tv[7] = '{1'b0, 5'd3, 64'h44,   1'b0, 5'd4, 64'h55,        1'b0, 1'b0, 1'b0, 5'd4,  64'h55,        32'h0000_0000, 16'd5};

    reset = 1'b1;
    drive(1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2);
    model_reset();

    // Reset held three cycles with both requesters valid
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_wr_en",      wr_en,      0);
      chk("rst_wr_addr",    wr_addr,    0);
      chk("rst_wr_data",    wr_data,    0);
      chk("rst_wr_sel",     wr_sel,     0);
      chk("rst_stall_cnt",  stall_cnt,  0);
    end
    reset = 1'b0;
    #1;
    chk("rel_req0_ready", req0_ready, 1);
    chk("rel_req1_ready", req1_ready, 0);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

    // Directed table: single requester, contention, zero register, idle
    for (int i = 0; i < 8; i++) begin
      drive(tv[i].v0, tv[i].a0, tv[i].d0, tv[i].v1, tv[i].a1, tv[i].d1);
      #1;
      chk("tv_req0_ready", req0_ready, tv[i].r0);
      chk("tv_req1_ready", req1_ready, tv[i].r1);
      @(posedge clk);
      model_clock(tv[i].v0, tv[i].a0, tv[i].d0, tv[i].v1, tv[i].a1, tv[i].d1);
      #2;
      chk("tv_wr_en",     wr_en,     tv[i].en);
      chk("tv_wr_addr",   wr_addr,   tv[i].addr);
      chk("tv_wr_data",   wr_data,   tv[i].data);
      chk("tv_wr_sel",    wr_sel,    tv[i].sel);
      chk("tv_stall_cnt", stall_cnt, tv[i].stall);
    end

    // Asynchronous reset between edges while a write is in flight
    cycle(1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0, 1'b1);
    chk("mid_wr_en_before", wr_en, 1);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_wr_en",     wr_en,     0);
    chk("mid_wr_sel",    wr_sel,    0);
    chk("mid_stall_cnt", stall_cnt, 0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    model_clock(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    #2;
    chk("post_rel_wr_en",  wr_en,  0);
    chk("post_rel_wr_sel", wr_sel, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit          v0, v1;
      logic [4:0]  a0, a1;
      logic [63:0] d0, d1;
      v0 = ($urandom_range(0, 9) < 7);
      v1 = ($urandom_range(0, 9) < 7);
      a0 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      cycle(v0, a0, d0, v1, a1, d1, 1'b1);
    end

    // Stall counter saturation from a clean reset
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 65534; i++) begin
      cycle(1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2, 1'b0);
    end
    chk("sat_preload", stall_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2, 1'b1);
      chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
    end

    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_regfile_wr_arbiter

`default_nettype wire
